mxv_result_tx: RTL and testbench
================================

Name: mxv_result_tx

Overview:
Transmit side of the host-link framing used by the matrix-vector unit. After a computation, the block reads N results from the result buffer and serialises a framed response onto the UART transmitter, one byte at a time. The frame is SOF, length, command, payload (each result MSB byte first), then EOF. It sits between the result buffer (synchronous read port) and the UART TX core (valid/ready byte interface).

Parameters:
DATA_W, 16, width of one result word; must be 16 (two payload bytes per result)
MAX_N, 8, maximum vector length accepted
ADDR_W, 3, result-buffer address width, clog2(MAX_N)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to send a response frame
N_input  in  4  number of results to send; sampled when start is accepted
rd_en  out  1  result-buffer read strobe
rd_addr  out  ADDR_W  result-buffer read address
rd_data  in  DATA_W  result word, valid the cycle after rd_en
tx_data  out  8  byte to UART TX
tx_valid  out  1  tx_data valid; held with tx_data stable until accepted
tx_ready  in  1  UART TX can accept a byte; transfer occurs when tx_valid & tx_ready
busy  out  1  high from start acceptance until the EOF transfer
done  out  1  one-cycle pulse in the cycle after the EOF transfer
err  out  1  one-cycle pulse when start is rejected for an illegal N

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. At the first edge with rst=1, every output goes to 0 (tx_data=0, rd_addr=0) and the state goes to IDLE. This holds mid-frame: the frame is abandoned and no EOF is sent.
- Frame contents: FE, L, 03, R0[15:8], R0[7:0], ..., R(N-1)[15:8], R(N-1)[7:0], EF.
  - L = 2*N+1 (command byte plus payload), computed in 8 bits.
  - Total frame length is 2N+4 bytes.
- States: IDLE, SOF, LEN, CMD, FETCH, WAIT_RD, DATA_HI, DATA_LO, EOF, DONE.
- IDLE, start accepted: when start=1 and 1<=N_input<=MAX_N:
  - latch N;
  - clear the index counter;
  - busy=1;
  - go to SOF.
  - tx_valid with FE is asserted in the cycle after start.
- IDLE, start rejected: start=1 with N_input=0 or N_input>MAX_N gives an err pulse next cycle and stays in IDLE. No bytes are sent.
- Start while busy: ignored, with no err.
- SOF, LEN, CMD: each state drives its byte with tx_valid=1. It advances only on a cycle where tx_ready=1; otherwise it holds, with tx_data unchanged.
- CMD accepted: go to FETCH.
- FETCH: rd_en=1 for exactly one cycle, rd_addr=index, then go to WAIT_RD.
- WAIT_RD: capture rd_data into a 16-bit holding register, then go to DATA_HI.
  - rd_addr holds its value while the result is consumed.
  - No tx_valid in FETCH or WAIT_RD.
- DATA_HI: sends hold[15:8]. On accept, go to DATA_LO.
- DATA_LO: sends hold[7:0]. On accept:
  - if index==N-1, go to EOF;
  - otherwise increment index and go to FETCH.
- EOF: sends EF. On accept, go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Back-to-back frames: a start arriving in the DONE cycle is ignored. The earliest new start is accepted in IDLE.
- Throughput:
  - with tx_ready tied high, one header/trailer byte per cycle;
  - each result costs 4 cycles (FETCH, WAIT_RD, HI, LO).
- tx_valid must never drop without a transfer, except on reset.

Decomposition:
- Additions to the shared mxv_pkg:
  - constants FRAME_SOF=8'hFE, FRAME_EOF=8'hEF, CMD_RESULT=8'h03, MAX_N=8;
  - the tx state enum type.
- One sub-module: mxv_tx_index_counter.
  - Inputs: clear, increment enable, terminal value N-1.
  - Outputs: index (ADDR_W) and a last flag.
- The state machine and byte mux stay in the top module.

Test Plan:
- N=2, results 0x0012 and 0xABCD, tx_ready=1 -> tx bytes FE,05,03,00,12,AB,CD,EF; FE valid one cycle after start; done pulses once, after the EF transfer.
- Same frame with tx_ready toggling randomly -> identical byte sequence; tx_data stable while tx_valid=1 and tx_ready=0; no byte duplicated or dropped.
- N=8, results 0x0101*i -> 20 bytes, L=8'h11; rd_addr sequence 0..7, each read exactly once.
- start with N_input=0, then N_input=9 -> err pulse for each; tx_valid never asserted; busy stays 0.
- rst=1 asserted during DATA_HI of result 1 -> next edge tx_valid=0, busy=0, state IDLE; a new start with N=1 yields FE,03,03,Rhi,Rlo,EF.
- start pulsed again during a frame and in the DONE cycle -> ignored, no err, only one frame emitted.

Source files
------------

// File: rtl/mxv_pkg.sv
// Shared definitions for the matrix-vector unit host link: frame bytes,
// size limits and the result-transmit state encoding.
package mxv_pkg;

   localparam int          MAX_N      = 8;
   localparam logic [7:0]  FRAME_SOF  = 8'hFE;
   localparam logic [7:0]  FRAME_EOF  = 8'hEF;
   localparam logic [7:0]  CMD_RESULT = 8'h03;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SOF,
      ST_LEN,
      ST_CMD,
      ST_FETCH,
      ST_WAIT_RD,
      ST_DATA_HI,
      ST_DATA_LO,
      ST_EOF,
      ST_DONE
   } tx_state_e;

   // Length byte covers the command byte plus two bytes per result: 2*N+1.
   function automatic logic [7:0] frame_len(input logic [3:0] n);
      return {3'd0, n, 1'b1};
   endfunction

endpackage

// File: rtl/mxv_tx_index_counter.sv
// Result index counter for the transmit framer; flags when the index
// has reached the last result of the frame.
module mxv_tx_index_counter #(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              inc,
   input  logic [ADDR_W-1:0] term,
   output logic [ADDR_W-1:0] index,
   output logic              last
);

   logic [ADDR_W-1:0] index_q;
   logic [ADDR_W-1:0] index_d;

   always_comb begin
      index_d = index_q;
      if (clear) begin
         index_d = '0;
      end else if (inc) begin
         index_d = index_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         index_q <= '0;
      end else begin
         index_q <= index_d;
      end
   end

   assign index = index_q;
   assign last  = (index_q == term);

endmodule

// File: rtl/mxv_result_tx.sv
// Reads N results from the result buffer and serialises them as a framed
// response (SOF, LEN, CMD, payload MSB first, EOF) onto a valid/ready byte link.
module mxv_result_tx #(
   parameter int DATA_W = 16,
   parameter int MAX_N  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        N_input,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);
   import mxv_pkg::*;

   localparam logic [3:0] MAX_N_L = 4'(MAX_N);

   tx_state_e         state_q, state_d;
   logic [3:0]        n_q, n_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              err_q, err_d;

   logic              cnt_clear;
   logic              cnt_inc;
   logic              cnt_last;
   logic [ADDR_W-1:0] index;
   logic [ADDR_W-1:0] term;
   logic              n_legal;

   assign n_legal = (N_input != 4'd0) && (N_input <= MAX_N_L);
   assign term    = ADDR_W'(n_q - 4'd1);

   mxv_tx_index_counter #(
      .ADDR_W (ADDR_W)
   ) u_index (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .term  (term),
      .index (index),
      .last  (cnt_last)
   );

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      hold_d    = hold_q;
      err_d     = 1'b0;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;
      rd_en     = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      busy      = 1'b1;
      done      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (n_legal) begin
                  n_d       = N_input;
                  cnt_clear = 1'b1;
                  state_d   = ST_SOF;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_SOF: begin
            tx_valid = 1'b1;
            tx_data  = FRAME_SOF;
            if (tx_ready) state_d = ST_LEN;
         end
         ST_LEN: begin
            tx_valid = 1'b1;
            tx_data  = frame_len(n_q);
            if (tx_ready) state_d = ST_CMD;
         end
         ST_CMD: begin
            tx_valid = 1'b1;
            tx_data  = CMD_RESULT;
            if (tx_ready) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            rd_en   = 1'b1;
            state_d = ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            hold_d  = rd_data;
            state_d = ST_DATA_HI;
         end
         ST_DATA_HI: begin
            tx_valid = 1'b1;
            tx_data  = hold_q[DATA_W-1 -: 8];
            if (tx_ready) state_d = ST_DATA_LO;
         end
         ST_DATA_LO: begin
            tx_valid = 1'b1;
            tx_data  = hold_q[7:0];
            if (tx_ready) begin
               if (cnt_last) begin
                  state_d = ST_EOF;
               end else begin
                  cnt_inc = 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_EOF: begin
            tx_valid = 1'b1;
            tx_data  = FRAME_EOF;
            if (tx_ready) state_d = ST_DONE;
         end
         ST_DONE: begin
            busy    = 1'b0;
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         n_q     <= 4'd0;
         hold_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
      end
   end

   // The read address is the live index so it stays put while a result drains.
   assign rd_addr = index;
   assign err     = err_q;

endmodule

// File: tb/tb_mxv_result_tx.sv
// Scoreboard bench for mxv_result_tx: stimulus queues expected bytes and
// read addresses, a negedge monitor pops and compares on every transfer.
module tb_mxv_result_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  N_input;
   logic        rd_en;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q[$];
   int          addr_q[$];
   logic [15:0] mem[8];
   int          ready_mode = 0;
   int          done_cnt = 0, done_exp = 0;
   int          err_cnt = 0, err_exp = 0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   logic        prev_eof = 1'b0;

   mxv_result_tx #(.DATA_W(16), .MAX_N(8), .ADDR_W(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .N_input  (N_input),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Result buffer with registered read.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = 1'($urandom_range(0, 1));
         default: tx_ready = 1'b0;
      endcase
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            done_cnt++;
            check("done_after_eof", int'(prev_eof), 1);
            check("busy_in_done", int'(busy), 0);
         end
         if (err) err_cnt++;
         if (prev_stall) begin
            check("stall_valid_held", int'(tx_valid), 1);
            check("stall_data_held", int'(tx_data), int'(prev_data));
         end
         if (rd_en) begin
            if (addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read actual=%0d required=no_read", rd_addr);
            end else begin
               check("rd_addr", int'(rd_addr), addr_q.pop_front());
            end
         end
         prev_eof = 1'b0;
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte actual=%0h required=no_byte", tx_data);
            end else begin
               check("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
            end
            prev_eof = (tx_data == 8'hEF);
         end
      end
      prev_stall = tx_valid && !tx_ready && !rst;
      prev_data  = tx_data;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input int n);
      exp_q.push_back(8'hFE);
      exp_q.push_back(8'(2 * n + 1));
      exp_q.push_back(8'h03);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(mem[i][15:8]);
         exp_q.push_back(mem[i][7:0]);
         addr_q.push_back(i);
      end
      exp_q.push_back(8'hEF);
   endtask

   task automatic do_start(input int n);
      @(posedge clk);
      #1;
      start   = 1'b1;
      N_input = 4'(n);
      @(posedge clk);
      #1;
      start   = 1'b0;
      N_input = 4'd0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, int'(seen), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      rst = 1'b1; start = 1'b0; N_input = 4'd0; tx_ready = 1'b1;
      cyc(3);
      check("reset_tx_valid", int'(tx_valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_rd_addr", int'(rd_addr), 0);
      check("reset_tx_data", int'(tx_data), 0);
      rst = 1'b0;
      cyc(2);

      // N=2, ready high; FE must appear exactly one cycle after start.
      mem[0] = 16'h0012; mem[1] = 16'hABCD;
      push_frame(2); done_exp++;
      @(posedge clk); #1;
      start = 1'b1; N_input = 4'd2;
      check("no_valid_in_start_cycle", int'(tx_valid), 0);
      @(posedge clk); #1;
      start = 1'b0; N_input = 4'd0;
      check("sof_valid_latency", int'(tx_valid), 1);
      check("sof_byte", int'(tx_data), 8'hFE);
      check("busy_after_start", int'(busy), 1);
      wait_done("frame_n2_done");
      check("idle_after_done", int'(busy), 0);

      // Same frame with random back-pressure.
      ready_mode = 1;
      push_frame(2); done_exp++;
      do_start(2);
      wait_done("frame_n2_random_done");
      ready_mode = 0;
      cyc(2);

      // Full-length frame.
      for (int i = 0; i < 8; i++) mem[i] = 16'(16'h0101 * i);
      push_frame(8); done_exp++;
      do_start(8);
      wait_done("frame_n8_done");

      // Illegal lengths.
      do_start(0); err_exp++;
      check("err_n0", int'(err), 1);
      check("err_n0_busy", int'(busy), 0);
      check("err_n0_valid", int'(tx_valid), 0);
      do_start(9); err_exp++;
      check("err_n9", int'(err), 1);
      check("err_n9_busy", int'(busy), 0);
      cyc(1);
      check("err_single_pulse", int'(err), 0);
      check("err_no_valid", int'(tx_valid), 0);

      // Reset while holding in DATA_HI of result 1.
      mem[0] = 16'h1234; mem[1] = 16'h5678;
      push_frame(2);
      do_start(2);
      found = 1'b0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (rd_en && rd_addr == 3'd1) begin
            found = 1'b1;
            break;
         end
      end
      check("reach_fetch_1", int'(found), 1);
      ready_mode = 2;
      cyc(2);
      check("data_hi_valid", int'(tx_valid), 1);
      check("data_hi_byte", int'(tx_data), 8'h56);
      rst = 1'b1;
      cyc(1);
      check("midrst_tx_valid", int'(tx_valid), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_rd_addr", int'(rd_addr), 0);
      check("midrst_tx_data", int'(tx_data), 0);
      rst = 1'b0;
      check("midrst_bytes_left", exp_q.size(), 3);
      exp_q.delete();
      ready_mode = 0;
      cyc(2);

      // N=1 after reset.
      mem[0] = 16'h5AA5;
      push_frame(1); done_exp++;
      do_start(1);
      wait_done("frame_n1_done");

      // Starts during a frame and in the DONE cycle are ignored.
      mem[0] = 16'h7E81;
      push_frame(1); done_exp++;
      do_start(1);
      cyc(1);
      start = 1'b1; N_input = 4'd0;
      cyc(1);
      start = 1'b0;
      check("busy_start_no_err", int'(err), 0);
      found = 1'b0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            break;
         end
      end
      check("ignore_frame_done", int'(found), 1);
      start = 1'b1; N_input = 4'd1;
      cyc(1);
      start = 1'b0; N_input = 4'd0;
      check("done_start_ignored_busy", int'(busy), 0);
      check("done_start_ignored_valid", int'(tx_valid), 0);
      check("done_start_no_err", int'(err), 0);
      cyc(6);
      check("still_idle", int'(busy), 0);

      check("bytes_outstanding", exp_q.size(), 0);
      check("reads_outstanding", addr_q.size(), 0);
      check("done_count", done_cnt, done_exp);
      check("err_count", err_cnt, err_exp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
